// File: rtl/hmr_pkg.sv
// Shared types for the runtime redundancy-mode controller.
package hmr_pkg;

    typedef enum logic [1:0] {
        MODE_INDEP = 2'd0,
        MODE_DMR   = 2'd1,
        MODE_TMR   = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        GRP_RUN,
        GRP_DRAIN,
        GRP_SETBACK,
        GRP_RESYNC
    } grp_state_e;

    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

endpackage

// File: rtl/hmr_group_fsm.sv
// Per-group recovery sequencer: RUN -> DRAIN -> SETBACK -> RESYNC -> RUN,
// holding the group mode, sticky fault, pending mode and error counter.
module hmr_group_fsm
    import hmr_pkg::*;
#(
    parameter int unsigned SetbackCycles = 4,
    parameter int unsigned ErrCntWidth   = 8,
    parameter logic [1:0]  DefaultMode   = 2'd0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_acc_i,
    input  logic [1:0]             req_mode_i,
    input  logic                   mismatch_i,
    input  logic                   uncorr_i,
    input  logic                   busy_any_i,
    output logic                   run_o,
    output logic                   setback_o,
    output logic [1:0]             mode_o,
    output logic                   fault_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);
    localparam int unsigned SbW = $clog2(SetbackCycles + 1);

    grp_state_e           state_q, state_d;
    logic [SbW-1:0]       sb_cnt_q, sb_cnt_d;
    mode_e                mode_q, mode_d;
    mode_e                pend_mode_q, pend_mode_d;
    logic                 pend_req_q, pend_req_d;
    logic                 fault_q, fault_d;
    logic [ErrCntWidth-1:0] err_q, err_d;
    logic                 mm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= GRP_RUN;
            sb_cnt_q    <= '0;
            mode_q      <= mode_e'(DefaultMode);
            pend_mode_q <= mode_e'(DefaultMode);
            pend_req_q  <= 1'b0;
            fault_q     <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            sb_cnt_q    <= sb_cnt_d;
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pend_req_q  <= pend_req_d;
            fault_q     <= fault_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sb_cnt_d    = sb_cnt_q;
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pend_req_d  = pend_req_q;
        fault_d     = fault_q;
        err_d       = err_q;
        // Mismatches only count while the group is live; recovery phases ignore them.
        mm          = (state_q == GRP_RUN) && mismatch_i;

        if (mm && (err_q != '1)) err_d = err_q + ErrCntWidth'(1);
        if (mm && uncorr_i) fault_d = 1'b1;

        unique case (state_q)
            GRP_RUN: begin
                if (req_acc_i || mm) begin
                    state_d    = GRP_DRAIN;
                    pend_req_d = req_acc_i;
                    if (req_acc_i) pend_mode_d = mode_e'(req_mode_i);
                end
            end
            GRP_DRAIN: begin
                if (!busy_any_i) begin
                    state_d  = GRP_SETBACK;
                    sb_cnt_d = SbW'(SetbackCycles - 1);
                end
            end
            GRP_SETBACK: begin
                if (sb_cnt_q == '0) state_d = GRP_RESYNC;
                else                sb_cnt_d = sb_cnt_q - SbW'(1);
            end
            GRP_RESYNC: begin
                state_d = GRP_RUN;
                if (pend_req_q) begin
                    mode_d  = pend_mode_q;
                    fault_d = 1'b0;
                end
            end
            default: state_d = GRP_RUN;
        endcase
    end

    assign run_o     = (state_q == GRP_RUN);
    assign setback_o = (state_q == GRP_SETBACK);
    assign mode_o    = mode_q;
    assign fault_o   = fault_q;
    assign err_cnt_o = err_q;

endmodule

// File: rtl/hmr_mode_ctrl.sv
// Runtime INDEP/DMR/TMR controller: per-group voting/compare, lane muxing and
// request arbitration in front of one recovery sequencer per core triple.
module hmr_mode_ctrl
    import hmr_pkg::*;
#(
    parameter int unsigned NumCores      = 6,
    parameter int unsigned BusWidth      = 72,
    parameter int unsigned SetbackCycles = 4,
    parameter int unsigned ErrCntWidth   = 8,
    parameter logic [1:0]  DefaultMode   = 2'd0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        mode_req_valid_i,
    output logic                                        mode_req_ready_o,
    input  logic [$clog2((NumCores/3 > 1) ? NumCores/3 : 2)-1:0] mode_req_group_i,
    input  logic [1:0]                                  mode_req_mode_i,
    input  logic [NumCores*BusWidth-1:0]                core_bus_i,
    input  logic [NumCores-1:0]                         core_busy_i,
    output logic [NumCores-1:0]                         core_setback_o,
    output logic [NumCores*BusWidth-1:0]                sys_bus_o,
    output logic [NumCores-1:0]                         sys_valid_o,
    output logic [(NumCores/3)*2-1:0]                   group_mode_o,
    output logic [NumCores/3-1:0]                       group_fault_o,
    output logic [(NumCores/3)*ErrCntWidth-1:0]         err_cnt_o
);
    localparam int unsigned NumGroups = NumCores / 3;
    localparam int unsigned GrpW      = $clog2((NumGroups > 1) ? NumGroups : 2);

    if ((NumCores % 3 != 0) || (NumCores == 0)) begin : g_bad_cores
        $fatal(1, "hmr_mode_ctrl: NumCores must be a non-zero multiple of 3");
    end
    if (SetbackCycles < 1) begin : g_bad_setback
        $fatal(1, "hmr_mode_ctrl: SetbackCycles must be at least 1");
    end

    logic [NumGroups-1:0]      run_g, acc_g, mism_g, uncorr_g, busy_g, setback_g;
    logic [NumGroups-1:0][1:0] mode_g;
    logic                      grp_ok;

    assign grp_ok           = 32'(mode_req_group_i) < NumGroups;
    assign mode_req_ready_o = !rst_i && grp_ok && run_g[mode_req_group_i];

    for (genvar g = 0; g < NumGroups; g++) begin : g_grp
        logic [BusWidth-1:0]      b0, b1, b2, maj;
        logic [2:0]               vld;
        logic [2:0][BusWidth-1:0] lane;

        assign b0  = core_bus_i[(3*g)*BusWidth +: BusWidth];
        assign b1  = core_bus_i[(3*g+1)*BusWidth +: BusWidth];
        assign b2  = core_bus_i[(3*g+2)*BusWidth +: BusWidth];
        assign maj = (b0 & b1) | (b0 & b2) | (b1 & b2);

        // Illegal modes are accepted at the port but never reach the group.
        assign acc_g[g] = mode_req_valid_i && mode_req_ready_o
                          && (mode_req_mode_i != MODE_ILLEGAL)
                          && (mode_req_group_i == GrpW'(g));

        assign mism_g[g]   = (mode_g[g] == MODE_TMR) ? |((b0 ^ b1) | (b0 ^ b2))
                           : (mode_g[g] == MODE_DMR) ? (b0 != b1) : 1'b0;
        assign uncorr_g[g] = (mode_g[g] == MODE_DMR) && (b0 != b1);
        assign busy_g[g]   = |core_busy_i[3*g +: 3];

        always_comb begin
            vld  = '0;
            lane = '0;
            if (run_g[g]) begin
                unique case (mode_g[g])
                    MODE_DMR: begin
                        vld     = 3'b101;
                        lane[0] = b0;
                        lane[2] = b2;
                    end
                    MODE_TMR: begin
                        vld     = 3'b001;
                        lane[0] = maj;
                    end
                    default: begin
                        vld     = 3'b111;
                        lane[0] = b0;
                        lane[1] = b1;
                        lane[2] = b2;
                    end
                endcase
            end
        end

        assign sys_bus_o[(3*g)*BusWidth +: 3*BusWidth] = lane;
        assign sys_valid_o[3*g +: 3]                   = vld;
        assign core_setback_o[3*g +: 3]                = {3{setback_g[g]}};
        assign group_mode_o[2*g +: 2]                  = mode_g[g];

        hmr_group_fsm #(
            .SetbackCycles (SetbackCycles),
            .ErrCntWidth   (ErrCntWidth),
            .DefaultMode   (DefaultMode)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .req_acc_i  (acc_g[g]),
            .req_mode_i (mode_req_mode_i),
            .mismatch_i (mism_g[g]),
            .uncorr_i   (uncorr_g[g]),
            .busy_any_i (busy_g[g]),
            .run_o      (run_g[g]),
            .setback_o  (setback_g[g]),
            .mode_o     (mode_g[g]),
            .fault_o    (group_fault_o[g]),
            .err_cnt_o  (err_cnt_o[g*ErrCntWidth +: ErrCntWidth])
        );
    end

endmodule

// File: tb/tb_hmr_mode_ctrl.sv
// Bench for hmr_mode_ctrl: directed scenarios plus randomized traffic against
// a cycle-count reference model of the group recovery behaviour.
module tb_hmr_mode_ctrl;
    localparam int NC = 6;
    localparam int NG = 2;
    localparam int BW = 72;
    localparam int SB = 4;
    localparam int EW = 2;
    localparam int DM = 2;
    localparam int CMAX = (1 << EW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode_req_valid, mode_req_ready;
    logic [0:0]        mode_req_group;
    logic [1:0]        mode_req_mode;
    logic [NC*BW-1:0]  core_bus, sys_bus;
    logic [NC-1:0]     core_busy, core_setback, sys_valid;
    logic [NG*2-1:0]   group_mode;
    logic [NG-1:0]     group_fault;
    logic [NG*EW-1:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Model: mode, fault, counter, pending request/mode, draining flag and
    // remaining post-drain cycles (SB setback cycles followed by one resync).
    int m_mode[NG], m_fault[NG], m_cnt[NG], m_pend[NG], m_preq[NG], m_drain[NG], m_post[NG];

    hmr_mode_ctrl #(
        .NumCores(NC), .BusWidth(BW), .SetbackCycles(SB),
        .ErrCntWidth(EW), .DefaultMode(2'(DM))
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mode_req_valid_i(mode_req_valid), .mode_req_ready_o(mode_req_ready),
        .mode_req_group_i(mode_req_group), .mode_req_mode_i(mode_req_mode),
        .core_bus_i(core_bus), .core_busy_i(core_busy), .core_setback_o(core_setback),
        .sys_bus_o(sys_bus), .sys_valid_o(sys_valid), .group_mode_o(group_mode),
        .group_fault_o(group_fault), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rnd72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] core(int i);
        return core_bus[i*BW +: BW];
    endfunction

    task automatic set_core(int i, logic [BW-1:0] v);
        core_bus[i*BW +: BW] = v;
    endtask

    task automatic set_all(logic [BW-1:0] v);
        for (int i = 0; i < NC; i++) core_bus[i*BW +: BW] = v;
    endtask

    function automatic logic [BW-1:0] vote(logic [BW-1:0] a, logic [BW-1:0] b, logic [BW-1:0] c);
        logic [BW-1:0] r;
        for (int i = 0; i < BW; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction

    function automatic bit m_run(int g);
        return (m_drain[g] == 0) && (m_post[g] == 0);
    endfunction

    function automatic bit m_mismatch(int g);
        logic [BW-1:0] a, b, c;
        a = core(3*g); b = core(3*g+1); c = core(3*g+2);
        if (m_mode[g] == 2) return !(a == b && b == c);
        if (m_mode[g] == 1) return a != b;
        return 1'b0;
    endfunction

    function automatic logic [NC*BW-1:0] exp_bus();
        logic [NC*BW-1:0] r;
        r = '0;
        for (int g = 0; g < NG; g++) begin
            if (m_run(g)) begin
                if (m_mode[g] == 0) begin
                    for (int k = 0; k < 3; k++) r[(3*g+k)*BW +: BW] = core(3*g+k);
                end else if (m_mode[g] == 1) begin
                    r[(3*g)*BW +: BW]   = core(3*g);
                    r[(3*g+2)*BW +: BW] = core(3*g+2);
                end else begin
                    r[(3*g)*BW +: BW] = vote(core(3*g), core(3*g+1), core(3*g+2));
                end
            end
        end
        return r;
    endfunction

    function automatic logic [NC-1:0] exp_valid();
        logic [NC-1:0] r;
        r = '0;
        for (int g = 0; g < NG; g++)
            if (m_run(g)) r[3*g +: 3] = (m_mode[g] == 0) ? 3'b111 : (m_mode[g] == 1) ? 3'b101 : 3'b001;
        return r;
    endfunction

    function automatic logic [NC-1:0] exp_setback();
        logic [NC-1:0] r;
        r = '0;
        for (int g = 0; g < NG; g++) if (m_post[g] >= 2) r[3*g +: 3] = 3'b111;
        return r;
    endfunction

    function automatic logic [NG*2-1:0] exp_mode();
        logic [NG*2-1:0] r;
        for (int g = 0; g < NG; g++) r[2*g +: 2] = 2'(m_mode[g]);
        return r;
    endfunction

    function automatic logic [NG-1:0] exp_fault();
        logic [NG-1:0] r;
        for (int g = 0; g < NG; g++) r[g] = (m_fault[g] != 0);
        return r;
    endfunction

    function automatic logic [NG*EW-1:0] exp_cnt();
        logic [NG*EW-1:0] r;
        for (int g = 0; g < NG; g++) r[g*EW +: EW] = EW'(m_cnt[g]);
        return r;
    endfunction

    function automatic logic exp_ready();
        return !rst && m_run(int'(mode_req_group));
    endfunction

    task automatic m_reset();
        for (int g = 0; g < NG; g++) begin
            m_mode[g] = DM; m_fault[g] = 0; m_cnt[g] = 0; m_pend[g] = DM;
            m_preq[g] = 0; m_drain[g] = 0; m_post[g] = 0;
        end
    endtask

    task automatic m_update();
        bit rq_ok;
        rq_ok = mode_req_valid && m_run(int'(mode_req_group)) && (mode_req_mode != 2'd3);
        for (int g = 0; g < NG; g++) begin
            bit run, acc, mm;
            run = m_run(g);
            acc = rq_ok && (int'(mode_req_group) == g);
            mm  = run && m_mismatch(g);
            if (run) begin
                if (mm) begin
                    if (m_cnt[g] < CMAX) m_cnt[g]++;
                    if (m_mode[g] == 1) m_fault[g] = 1;
                end
                if (acc || mm) begin
                    m_drain[g] = 1;
                    m_preq[g]  = acc;
                    if (acc) m_pend[g] = int'(mode_req_mode);
                end
            end else if (m_drain[g] != 0) begin
                if (core_busy[3*g +: 3] == 3'b000) begin
                    m_drain[g] = 0;
                    m_post[g]  = SB + 1;
                end
            end else begin
                m_post[g]--;
                if (m_post[g] == 0 && m_preq[g] != 0) begin
                    m_mode[g]  = m_pend[g];
                    m_fault[g] = 0;
                end
            end
        end
    endtask

    // Every rising edge goes through here so the model never skips a cycle.
    task automatic step();
        @(posedge clk);
        if (rst) m_reset(); else m_update();
        #1;
    endtask

    task automatic req(int g, int m);
        mode_req_valid = 1'b1;
        mode_req_group = 1'(g);
        mode_req_mode  = 2'(m);
    endtask

    task automatic test_reset();
        rst = 1'b1; core_busy = '0; set_all(72'hA5);
        req(0, 1);
        m_reset();
        @(negedge clk);
        checks++; if (sys_bus[BW-1:0] !== 72'hA5) begin errors++; $display("FAIL reset_lane0: got %h expected %h", sys_bus[BW-1:0], 72'hA5); end
        checks++; if (sys_valid !== 6'b001001) begin errors++; $display("FAIL reset_valid: got %b expected %b", sys_valid, 6'b001001); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_errcnt: got %h expected 0", err_cnt); end
        checks++; if (mode_req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", mode_req_ready); end
        checks++; if (core_setback !== '0 || group_fault !== '0) begin errors++; $display("FAIL reset_setback_fault: got %b/%b expected 0/0", core_setback, group_fault); end
        checks++; if (group_mode !== 4'b1010) begin errors++; $display("FAIL reset_mode: got %b expected 1010", group_mode); end
        step();
        rst = 1'b0; mode_req_valid = 1'b0;
    endtask

    task automatic test_tmr_flip();
        logic [BW-1:0] base, bad;
        logic [2:0] exp_sb;
        base = rnd72(); set_all(base);
        bad = base; bad[3] = ~bad[3]; set_core(1, bad);
        @(negedge clk);
        checks++; if (sys_bus[BW-1:0] !== base) begin errors++; $display("FAIL tmr_vote: got %h expected %h", sys_bus[BW-1:0], base); end
        checks++; if (sys_valid[2:0] !== 3'b001) begin errors++; $display("FAIL tmr_valid: got %b expected 001", sys_valid[2:0]); end
        step();
        set_core(1, base);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (err_cnt[EW-1:0] !== 2'd1) begin errors++; $display("FAIL tmr_errcnt: got %0d expected 1", err_cnt[EW-1:0]); end
            end
            exp_sb = (k >= 2 && k <= 5) ? 3'b111 : 3'b000;
            checks++; if (core_setback[2:0] !== exp_sb) begin errors++; $display("FAIL tmr_setback_c%0d: got %b expected %b", k, core_setback[2:0], exp_sb); end
            checks++; if (sys_valid[0] !== (k == 7)) begin errors++; $display("FAIL tmr_run_c%0d: got %b expected %b", k, sys_valid[0], k == 7); end
            step();
        end
    endtask

    task automatic test_dmr_fault();
        logic [BW-1:0] base, bad;
        base = rnd72(); set_all(base);
        req(1, 1);
        @(negedge clk);
        checks++; if (mode_req_ready !== 1'b1) begin errors++; $display("FAIL dmr_req_ready: got %b expected 1", mode_req_ready); end
        step();
        mode_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin @(negedge clk); step(); end
        @(negedge clk);
        checks++; if (group_mode[3:2] !== 2'd1 || sys_valid[5:3] !== 3'b101) begin errors++; $display("FAIL dmr_enter: got mode %0d valid %b expected 1 101", group_mode[3:2], sys_valid[5:3]); end
        bad = base; bad[$urandom_range(BW-1)] ^= 1'b1; set_core(3, bad);
        step();
        set_core(3, base);
        @(negedge clk);
        checks++; if (group_fault[1] !== 1'b1 || err_cnt[2*EW-1:EW] !== 2'd1) begin errors++; $display("FAIL dmr_fault_set: got fault %b cnt %0d expected 1 1", group_fault[1], err_cnt[2*EW-1:EW]); end
        step();
        for (int k = 2; k <= 6; k++) begin @(negedge clk); step(); end
        @(negedge clk);
        checks++; if (group_fault[1] !== 1'b1 || group_mode[3:2] !== 2'd1) begin errors++; $display("FAIL dmr_fault_sticky: got fault %b mode %0d expected 1 1", group_fault[1], group_mode[3:2]); end
        req(1, 1);
        step();
        mode_req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin @(negedge clk); step(); end
        @(negedge clk);
        checks++; if (group_fault[1] !== 1'b1) begin errors++; $display("FAIL dmr_fault_resync: got %b expected 1", group_fault[1]); end
        step();
        @(negedge clk);
        checks++; if (group_fault[1] !== 1'b0) begin errors++; $display("FAIL dmr_fault_clear: got %b expected 0", group_fault[1]); end
        step();
    endtask

    task automatic test_busy_drain();
        int nd, ns;
        bit found;
        req(0, 0);
        @(negedge clk); step();
        mode_req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin @(negedge clk); step(); end
        core_busy[2] = 1'b1;
        req(0, 2);
        @(negedge clk);
        checks++; if (group_mode[1:0] !== 2'd0 || sys_valid[2:0] !== 3'b111) begin errors++; $display("FAIL indep_enter: got mode %0d valid %b expected 0 111", group_mode[1:0], sys_valid[2:0]); end
        step();
        mode_req_valid = 1'b0;
        nd = 0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            core_busy[2] = (i < 9);
            @(negedge clk);
            if (core_setback[2:0] === 3'b111) found = 1'b1;
            else begin
                nd++;
                checks++; if (sys_valid[2:0] !== 3'b000) begin errors++; $display("FAIL drain_valid: got %b expected 000", sys_valid[2:0]); end
            end
            step();
        end
        checks++; if (!found || nd != 10) begin errors++; $display("FAIL drain_len: got %0d cycles (setback seen %0d) expected 10", nd, found); end
        ns = 1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (core_setback[2:0] === 3'b111) ns++;
            step();
        end
        checks++; if (ns != SB) begin errors++; $display("FAIL busy_setback_len: got %0d expected %0d", ns, SB); end
        @(negedge clk);
        checks++; if (group_mode[1:0] !== 2'd2) begin errors++; $display("FAIL busy_mode_tmr: got %0d expected 2", group_mode[1:0]); end
        step();
    endtask

    task automatic test_illegal_and_blocked();
        logic [BW-1:0] base, bad;
        int wait_n;
        bit seen;
        base = rnd72(); set_all(base);
        req(0, 3);
        @(negedge clk);
        checks++; if (mode_req_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", mode_req_ready); end
        step();
        mode_req_valid = 1'b0;
        @(negedge clk);
        checks++; if (group_mode !== 4'b0110 || sys_valid[2:0] !== 3'b001) begin errors++; $display("FAIL illegal_dropped: got mode %b valid %b expected 0110 001", group_mode, sys_valid[2:0]); end
        bad = base; bad[$urandom_range(BW-1)] ^= 1'b1; set_core(0, bad);
        step();
        set_core(0, base);
        @(negedge clk); step();
        req(0, 2);
        @(negedge clk);
        checks++; if (core_setback[2:0] !== 3'b111 || mode_req_ready !== 1'b0) begin errors++; $display("FAIL blocked_ready: got setback %b ready %b expected 111 0", core_setback[2:0], mode_req_ready); end
        step();
        wait_n = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            checks++; if (mode_req_ready !== exp_ready()) begin errors++; $display("FAIL blocked_ready_track: got %b expected %b", mode_req_ready, exp_ready()); end
            if (mode_req_ready === 1'b1) seen = 1'b1; else wait_n++;
            step();
        end
        mode_req_valid = 1'b0;
        checks++; if (!seen || wait_n != 4) begin errors++; $display("FAIL blocked_wait: got %0d cycles expected 4", wait_n); end
        for (int k = 1; k <= 6; k++) begin @(negedge clk); step(); end
    endtask

    task automatic test_saturation();
        logic [BW-1:0] base, bad;
        base = rnd72(); set_all(base);
        for (int n = 0; n < 5; n++) begin
            bad = base; bad[$urandom_range(BW-1)] ^= 1'b1; set_core($urandom_range(2), bad);
            @(negedge clk); step();
            set_all(base);
            @(negedge clk);
            checks++; if (err_cnt !== exp_cnt()) begin errors++; $display("FAIL sat_step%0d: got %h expected %h", n, err_cnt, exp_cnt()); end
            step();
            for (int k = 2; k <= 6; k++) begin @(negedge clk); step(); end
        end
        @(negedge clk);
        checks++; if (err_cnt[EW-1:0] !== 2'd3) begin errors++; $display("FAIL sat_final: got %0d expected 3", err_cnt[EW-1:0]); end
        step();
    endtask

    task automatic test_random();
        logic [BW-1:0] base;
        int c, b;
        for (int n = 0; n < 400; n++) begin
            for (int g = 0; g < NG; g++) begin
                base = rnd72();
                for (int k = 0; k < 3; k++) set_core(3*g+k, (m_mode[g] == 0) ? rnd72() : base);
                if ($urandom_range(9) == 0) begin
                    c = 3*g + int'($urandom_range(2));
                    b = int'($urandom_range(BW-1));
                    core_bus[c*BW + b] = ~core_bus[c*BW + b];
                end
            end
            for (int i = 0; i < NC; i++) core_busy[i] = ($urandom_range(4) == 0);
            mode_req_valid = ($urandom_range(3) == 0);
            mode_req_group = 1'($urandom_range(1));
            mode_req_mode  = 2'($urandom_range(3));
            @(negedge clk);
            checks++; if (sys_bus !== exp_bus()) begin errors++; $display("FAIL rnd_bus: got %h expected %h", sys_bus, exp_bus()); end
            checks++; if (sys_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid: got %b expected %b", sys_valid, exp_valid()); end
            checks++; if (core_setback !== exp_setback()) begin errors++; $display("FAIL rnd_setback: got %b expected %b", core_setback, exp_setback()); end
            checks++; if (group_mode !== exp_mode()) begin errors++; $display("FAIL rnd_mode: got %b expected %b", group_mode, exp_mode()); end
            checks++; if (group_fault !== exp_fault()) begin errors++; $display("FAIL rnd_fault: got %b expected %b", group_fault, exp_fault()); end
            checks++; if (err_cnt !== exp_cnt()) begin errors++; $display("FAIL rnd_errcnt: got %h expected %h", err_cnt, exp_cnt()); end
            checks++; if (mode_req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready: got %b expected %b", mode_req_ready, exp_ready()); end
            step();
        end
        mode_req_valid = 1'b0; core_busy = '0; set_all(rnd72());
        for (int k = 0; k < 12; k++) begin @(negedge clk); step(); end
    endtask

    task automatic test_reset_mid();
        req(0, 1);
        @(negedge clk);
        checks++; if (mode_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", mode_req_ready); end
        step();
        mode_req_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin @(negedge clk); step(); end
        @(negedge clk);
        checks++; if (core_setback[2:0] !== 3'b111) begin errors++; $display("FAIL rstmid_in_setback: got %b expected 111", core_setback[2:0]); end
        rst = 1'b1;
        #1;
        m_reset();
        checks++; if (core_setback !== '0) begin errors++; $display("FAIL rstmid_setback: got %b expected 0", core_setback); end
        checks++; if (group_mode !== 4'b1010 || err_cnt !== '0 || group_fault !== '0) begin errors++; $display("FAIL rstmid_state: got mode %b cnt %h fault %b expected 1010 0 0", group_mode, err_cnt, group_fault); end
        checks++; if (sys_valid !== 6'b001001 || mode_req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: got valid %b ready %b expected 001001 0", sys_valid, mode_req_ready); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (group_mode !== 4'b1010 || sys_valid !== 6'b001001) begin errors++; $display("FAIL rstmid_after: got mode %b valid %b expected 1010 001001", group_mode, sys_valid); end
        step();
    endtask

    initial begin
        mode_req_valid = 1'b0; mode_req_group = '0; mode_req_mode = '0;
        core_bus = '0; core_busy = '0; rst = 1'b1;
        test_reset();
        test_tmr_flip();
        test_dmr_fault();
        test_busy_drain();
        test_illegal_and_blocked();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
